// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word.sv
// Big-endian byte-to-word assembler: keeps the leading bytes of a word and
// presents the full word in the cycle its last byte arrives.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_shift_en,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  // The final byte goes straight to the output, so only the leading bytes are stored.
  logic [23:0]      r_shreg;
  logic [CNT_W-1:0] r_cnt;

  // Shift register and byte counter; the counter wraps to 0 after each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= 24'h000000;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_shreg <= 24'h000000;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_shift_en) begin
      r_shreg <= {r_shreg[15:0], i_byte};
      r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_shreg <= r_shreg;
      r_cnt   <= r_cnt;
    end
  end

  assign o_word      = {r_shreg, i_byte};
  assign o_word_full = i_shift_en && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory
// and holds the CPU until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam int              LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W:0]  DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_e             r_state;
  state_e             w_state_next;
  logic [LEN_W-1:0]   r_len;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               w_xfer;
  logic               w_shift_en;
  logic               w_clear;
  logic               w_word_full;
  logic               w_last_word;
  logic [31:0]        w_word;
  logic [LEN_W-1:0]   w_len_n;

  assign w_xfer      = i_byte_valid && o_byte_ready;
  assign w_len_n     = {r_len[LEN_W-1:8], i_byte_in};
  // Last-word test is one bit wider than the length so N = depth compares cleanly.
  assign w_last_word = ((LEN_W+1)'(r_addr) + (LEN_W+1)'(1)) == {1'b0, r_len};

  word_assembler u_word (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_shift_en  (w_shift_en),
    .i_clear     (w_clear),
    .i_byte      (i_byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // Next-state logic; start is honoured only in the idle-like states.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          w_state_next = ST_LEN_HI;
          w_clear      = 1'b1;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_LEN_HI: begin
        if (w_xfer) w_state_next = ST_LEN_LO;
        else        w_state_next = r_state;
      end
      ST_LEN_LO: begin
        if (!w_xfer)                          w_state_next = r_state;
        else if (w_len_n == {LEN_W{1'b0}})    w_state_next = ST_DONE;
        else if ({1'b0, w_len_n} > DEPTH)     w_state_next = ST_ERR;
        else                                  w_state_next = ST_DATA;
      end
      ST_DATA: begin
        w_shift_en = w_xfer;
        if (w_word_full) w_state_next = ST_WRITE;
        else             w_state_next = r_state;
      end
      ST_WRITE: begin
        if (w_last_word) w_state_next = ST_DONE;
        else             w_state_next = ST_DATA;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Length, address and write-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= {LEN_W{1'b0}};
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= 32'h0000_0000;
    end else begin
      if (r_state == ST_LEN_HI && w_xfer)      r_len[LEN_W-1:8] <= i_byte_in;
      else if (r_state == ST_LEN_LO && w_xfer) r_len[7:0]       <= i_byte_in;
      else                                     r_len            <= r_len;

      if (w_clear)                 r_addr <= {ADDR_W{1'b0}};
      else if (r_state == ST_WRITE) r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      else                         r_addr <= r_addr;

      if (w_word_full) r_wdata <= w_word;
      else             r_wdata <= r_wdata;
    end
  end

  // Status outputs are decoded from the next state so they register with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_byte_ready <= 1'b0;
      o_im_we      <= 1'b0;
      o_cpu_hold   <= 1'b1;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_byte_ready <= w_state_next inside {ST_LEN_HI, ST_LEN_LO, ST_DATA};
      o_im_we      <= (w_state_next == ST_WRITE);
      o_cpu_hold   <= (w_state_next != ST_DONE);
      o_done       <= (w_state_next == ST_DONE);
      o_error      <= (w_state_next == ST_ERR);
    end
  end

  assign o_im_addr  = r_addr;
  assign o_im_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: image words are the
// reference, expected writes are simply word i at address i.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_im_we;
  logic [7:0]  o_im_addr;
  logic [31:0] o_im_wdata;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] img[$];
  logic [31:0] cap_data[$];
  logic [7:0]  cap_addr[$];

  imem_loader #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_im_we      (o_im_we),
    .o_im_addr    (o_im_addr),
    .o_im_wdata   (o_im_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every memory write the loader issues.
  always @(negedge clk) begin
    if (o_im_we === 1'b1) begin
      cap_addr.push_back(o_im_addr);
      cap_data.push_back(o_im_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, o_byte_ready, 1'b0);
    chk({tag, "_we"},    o_im_we,      1'b0);
    chk({tag, "_addr"},  o_im_addr,    8'h00);
    chk({tag, "_wdata"}, o_im_wdata,   32'h0);
    chk({tag, "_hold"},  o_cpu_hold,   1'b1);
    chk({tag, "_done"},  o_done,       1'b0);
    chk({tag, "_error"}, o_error,      1'b0);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic push_byte(input logic [7:0] b, input int gap_pct);
    int t;
    while ($urandom_range(0, 99) < gap_pct) begin
      i_byte_valid = 1'b0;
      @(negedge clk);
    end
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    t = 0;
    while (!o_byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_byte_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // One load session of n words from img; glitch_at/abort_at are data-byte indices (-1 = none).
  task automatic run_session(input int n, input int gap_pct, input int glitch_at, input int abort_at);
    logic [15:0] len;
    logic [31:0] word;
    len = 16'(n);
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_ready", o_byte_ready, 1'b1);
    chk("start_hold",  o_cpu_hold,   1'b1);
    chk("start_done",  o_done,       1'b0);
    chk("start_error", o_error,      1'b0);
    push_byte(len[15:8], gap_pct);
    push_byte(len[7:0],  gap_pct);
    if (n == 0) begin
      chk("n0_done",  o_done,       1'b1);
      chk("n0_hold",  o_cpu_hold,   1'b0);
      chk("n0_ready", o_byte_ready, 1'b0);
      @(negedge clk);
      chk("n0_writes", cap_data.size(), 32'd0);
      return;
    end
    if (n > 256) begin
      chk("err_error", o_error,      1'b1);
      chk("err_hold",  o_cpu_hold,   1'b1);
      chk("err_ready", o_byte_ready, 1'b0);
      chk("err_done",  o_done,       1'b0);
      repeat (3) @(negedge clk);
      chk("err_writes", cap_data.size(), 32'd0);
      chk("err_stays",  o_error,        1'b1);
      return;
    end
    for (int w = 0; w < n; w++) begin
      word = img[w];
      for (int b = 0; b < 4; b++) begin
        if (abort_at == w * 4 + b) begin
          rst_n = 1'b0;
          #1;
          chk_reset_values("abort");
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk("abort_writes", cap_data.size(), 32'(abort_at / 4));
          if (cap_data.size() > 0) begin
            chk("abort_w0_addr", cap_addr[0], 8'h00);
            chk("abort_w0_data", cap_data[0], img[0]);
          end
          return;
        end
        if (glitch_at == w * 4 + b) begin
          i_start = 1'b1;
          @(negedge clk);
          i_start = 1'b0;
          chk("glitch_ready", o_byte_ready, 1'b1);
          chk("glitch_addr",  o_im_addr,    32'(w));
          chk("glitch_hold",  o_cpu_hold,   1'b1);
        end
        push_byte(word[31 - 8 * b -: 8], gap_pct);
      end
      chk("write_we",    o_im_we,      1'b1);
      chk("write_addr",  o_im_addr,    32'(w));
      chk("write_data",  o_im_wdata,   word);
      chk("write_ready", o_byte_ready, 1'b0);
      chk("write_hold",  o_cpu_hold,   1'b1);
    end
    @(negedge clk);
    chk("fin_done",  o_done,     1'b1);
    chk("fin_hold",  o_cpu_hold, 1'b0);
    chk("fin_we",    o_im_we,    1'b0);
    chk("fin_wdata", o_im_wdata, img[n - 1]);
    @(negedge clk);
    chk("fin_writes", cap_data.size(), 32'(n));
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      chk("cap_addr", cap_addr[i], 32'(i));
      chk("cap_data", cap_data[i], img[i]);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_byte_in    = 8'h00;
    i_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    img.delete();
    img.push_back(32'h2008_0005);
    img.push_back(32'h2109_FFFF);
    run_session(2, 0, -1, -1);

    img.delete();
    run_session(0, 0, -1, -1);

    run_session(257, 0, -1, -1);
    rand_img(1);
    run_session(1, 0, -1, -1);

    rand_img(4);
    run_session(4, 50, -1, -1);

    rand_img(4);
    run_session(4, 30, -1, 6);
    rand_img(3);
    run_session(3, 0, -1, -1);

    rand_img(3);
    run_session(3, 20, 2, -1);

    rand_img(256);
    run_session(256, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the MIPS instruction memory from an external source and holds the CPU until the image is complete. It is the writing end of the instruction memory, which the CPU fetch path reads. It replaces file-based preloading for hardware bring-up and lets benches load programs through a real port. It sits between a byte source (UART receiver or bench driver) and the instruction-memory write port, and drives the CPU hold line.

## Interface
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load session
- byte_in  in  8  incoming stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts byte_in this cycle
- im_we  out  1  instruction-memory write enable, one cycle per word
- im_addr  out  ADDR_W  word address for the write
- im_wdata  out  32  instruction word
- cpu_hold  out  1  CPU held in reset while high
- done  out  1  load completed successfully; level signal
- error  out  1  declared length exceeds depth; level signal

## Operation
- Stream format, big-endian:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - Then 4·N bytes. Each group of 4 bytes forms one instruction word, first byte = bits 31:24.
- A byte transfers only when byte_valid && byte_ready.
- States:
  - IDLE: on start → LEN_HI; clear done, error, address and byte counter.
  - LEN_HI: on transfer, capture high byte → LEN_LO.
  - LEN_LO: on transfer, capture low byte. N = 0 → DONE. N > 2^ADDR_W → ERR. Otherwise → DATA.
  - DATA: shift in bytes. On the 4th transfer → WRITE.
  - WRITE: assert im_we with the current address and the assembled word. Then increment the address. If words written = N → DONE, else → DATA.
  - DONE: done = 1, cpu_hold = 0. On start → LEN_HI, which restarts the session.
  - ERR: error = 1, cpu_hold stays 1. On start → LEN_HI.
- byte_ready is 1 in LEN_HI, LEN_LO and DATA, and 0 in every other state.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE; a session cannot be aborted except by reset.
- cpu_hold is 1 in every state except DONE.
- Address counter is ADDR_W bits wide. It never wraps, because the N ≤ 2^ADDR_W check occurs before any write.
- Byte counter is 2 bits and resets to 0 after each word.

## Timing
- Reset values: byte_ready = 0, im_we = 0, im_addr = 0, im_wdata = 0, cpu_hold = 1, done = 0, error = 0, state = IDLE.
- Asserting rst_n low mid-load aborts the session immediately. No partial word is written, and already-written words remain in memory.
- The cycle after start, byte_ready = 1.
- The 4th data byte transfers at edge k; im_we = 1 during cycle k+1, and byte_ready = 0 in that cycle. Sustained throughput is 4 bytes per 5 cycles.
- im_addr and im_wdata are stable for the entire im_we cycle. im_wdata holds its last value afterwards.
- After the final write cycle, done = 1 and cpu_hold = 0 on the next edge.
- byte_valid may drop between bytes; the loader waits indefinitely, with no timeout.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR);
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4.
- One natural sub-module, word_assembler, provides:
  - a 32-bit shift register with a 2-bit byte counter;
  - inputs: shift enable, clear;
  - output: word_full.
- The FSM, address counter and length register stay in imem_loader.

## Test plan
- Load of N = 2 (bytes 00 02 20 08 00 05 21 09 FF FF):
  - im_we at addr 0 with 0x20080005, then at addr 1 with 0x2109FFFF;
  - done = 1 and cpu_hold = 0 one cycle after the second write.
- N = 0 (bytes 00 00): DONE with no im_we pulse; cpu_hold falls 1 cycle after LEN_LO.
- ADDR_W = 8, N = 0x0101: error = 1, cpu_hold = 1, no writes, byte_ready = 0. A following start with N = 1 loads correctly.
- Random byte_valid gaps (about 50% duty) on a 4-word image: written words and addresses match, and exactly 4 im_we pulses occur.
- rst_n low after 6 data bytes:
  - all outputs return to reset values asynchronously;
  - only word 0 is written;
  - a fresh session loads correctly.
- start pulsed during DATA is ignored, with no state or address change. start in DONE restarts a session with address 0 and cpu_hold = 1.
